// File: rtl/chicken_game_core_pkg.sv
// Shared types and helpers for the Chicken Cha-Cha-Cha game datapath:
// FSM state encoding, derived-width helpers and the player-count clamp.
package chicken_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        SCAN,
        RESOLVE,
        WIN
    } state_t;

    function automatic int pw_of(input int max_players);
        return (max_players < 2) ? 1 : $clog2(max_players);
    endfunction

    function automatic int aw_of(input int track_len);
        return (track_len < 2) ? 1 : $clog2(track_len);
    endfunction

    function automatic int tw_of(input int max_players);
        return $clog2(max_players + 1);
    endfunction

    function automatic int clamp_players(input int n, input int max_p);
        if (n < 2)
            return 2;
        if (n > max_p)
            return max_p;
        return n;
    endfunction

endpackage

// File: rtl/chicken_game_core_if.sv
// Guess/result handshake between the card front-end (master) and the game
// core (slave).
interface chicken_game_core_if #(
    parameter int IMG_W = 4
);
    logic             guess_valid;
    logic [IMG_W-1:0] guess_img;
    logic             guess_ready;
    logic             result_valid;
    logic             result_match;
    logic             result_steal;

    modport master (
        output guess_valid,
        output guess_img,
        input  guess_ready,
        input  result_valid,
        input  result_match,
        input  result_steal
    );

    modport slave (
        input  guess_valid,
        input  guess_img,
        output guess_ready,
        output result_valid,
        output result_match,
        output result_steal
    );

endinterface

// File: rtl/chicken_game_core_next_player_sel.sv
// Rotate-priority finder: first active player after i_turn, wrapping at i_np.
// Falls back to i_turn itself when no other player is active.
module next_player_sel #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_active,
    input  logic [PW-1:0] i_turn,
    input  logic [PW:0]   i_np,
    output logic [PW-1:0] o_next
);

    int   w_cand;
    logic w_found;

    always_comb begin
        o_next  = i_turn;
        w_cand  = int'(i_turn);
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand = (w_cand + 1 >= int'(i_np)) ? 0 : w_cand + 1;
            for (int j = 0; j < N; j++) begin
                if (!w_found && (j == w_cand) && i_active[j]) begin
                    w_found = 1'b1;
                    o_next  = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/chicken_game_core.sv
// Game datapath: tile track, player positions/tails, turn, and the multi-cycle
// guess evaluation (skip occupied tiles, move, steal tails, rotate, win).
module chicken_game_core
    import chicken_pkg::*;
#(
    parameter  int MAX_PLAYERS = 4,
    parameter  int TRACK_LEN   = 16,
    parameter  int IMG_W       = 4,
    localparam int PW          = pw_of(MAX_PLAYERS),
    localparam int AW          = aw_of(TRACK_LEN),
    localparam int TW          = tw_of(MAX_PLAYERS),
    localparam int NPW         = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NPW-1:0]        num_players,
    input  logic                  tile_wr_en,
    input  logic [AW-1:0]         tile_wr_addr,
    input  logic [IMG_W-1:0]      tile_wr_img,
    chicken_game_core_if.slave    bus,
    output logic [PW-1:0]         turn,
    output logic                  winner_valid,
    output logic [PW-1:0]         winner,
    input  logic [PW-1:0]         dbg_sel,
    output logic [AW-1:0]         dbg_pos,
    output logic [TW-1:0]         dbg_tails
);

    localparam logic [AW:0] TL      = TRACK_LEN[AW:0];
    localparam int          SPACING = TRACK_LEN / MAX_PLAYERS;

    state_t           r_state;
    logic [IMG_W-1:0] r_tile  [TRACK_LEN];
    logic [AW-1:0]    r_pos   [MAX_PLAYERS];
    logic [TW-1:0]    r_tails [MAX_PLAYERS];
    logic [PW-1:0]    r_turn;
    logic [NPW-1:0]   r_np;
    logic [NPW-1:0]   r_off;
    logic [IMG_W-1:0] r_guess;
    logic             r_guess_ready;
    logic             r_result_valid;
    logic             r_result_match;
    logic             r_result_steal;
    logic             r_winner_valid;
    logic [PW-1:0]    r_winner;

    logic [MAX_PLAYERS-1:0] w_active;
    logic [MAX_PLAYERS-1:0] w_steal_mask;
    logic [AW-1:0]          w_cur_pos;
    logic [AW-1:0]          w_target;
    logic [AW-1:0]          w_dist;
    logic                   w_occupied;
    logic                   w_match;
    logic [TW-1:0]          w_steal_sum;
    logic [TW-1:0]          w_new_tails;
    logic                   w_win;
    logic [PW-1:0]          w_next;
    logic [NPW-1:0]         w_np_clamped;

    function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= TL)
            s = s - TL;
        return s[AW-1:0];
    endfunction

    // Forward distance from b to a around the ring.
    function automatic logic [AW-1:0] sub_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + TL - {1'b0, b};
        if (s >= TL)
            s = s - TL;
        return s[AW-1:0];
    endfunction

    assign w_np_clamped = NPW'(clamp_players(int'(num_players), MAX_PLAYERS));

    always_comb begin
        w_active     = '0;
        w_steal_mask = '0;
        w_steal_sum  = '0;
        w_occupied   = 1'b0;
        w_dist       = '0;
        w_cur_pos    = r_pos[r_turn];
        w_target     = add_mod(w_cur_pos, AW'(r_off));
        for (int j = 0; j < MAX_PLAYERS; j++) begin
            w_active[j] = (j < int'(r_np)) && (r_tails[j] != '0);
        end
        // Skipped tiles lie strictly between the current position and the target.
        for (int j = 0; j < MAX_PLAYERS; j++) begin
            if (w_active[j] && (r_pos[j] == w_target))
                w_occupied = 1'b1;
            w_dist = sub_mod(r_pos[j], w_cur_pos);
            if (w_active[j] && (PW'(j) != r_turn) && (w_dist != '0) && (w_dist < AW'(r_off))) begin
                w_steal_mask[j] = 1'b1;
                w_steal_sum     = w_steal_sum + r_tails[j];
            end
        end
        w_match     = (r_tile[w_target] == r_guess);
        w_new_tails = r_tails[r_turn] + w_steal_sum;
        w_win       = (w_new_tails == TW'(r_np));
    end

    next_player_sel #(
        .N  (MAX_PLAYERS),
        .PW (PW)
    ) u_next_player_sel (
        .i_active (w_active),
        .i_turn   (r_turn),
        .i_np     (r_np),
        .o_next   (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_turn         <= '0;
            r_np           <= '0;
            r_off          <= '0;
            r_guess        <= '0;
            r_guess_ready  <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_match <= 1'b0;
            r_result_steal <= 1'b0;
            r_winner_valid <= 1'b0;
            r_winner       <= '0;
            for (int i = 0; i < TRACK_LEN; i++)
                r_tile[i] <= '0;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                r_pos[i]   <= '0;
                r_tails[i] <= '0;
            end
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tile_wr_en && (int'(tile_wr_addr) < TRACK_LEN))
                        r_tile[tile_wr_addr] <= tile_wr_img;
                    if (start) begin
                        r_np    <= w_np_clamped;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    for (int i = 0; i < MAX_PLAYERS; i++) begin
                        r_pos[i]   <= AW'(i * SPACING);
                        r_tails[i] <= (i < int'(r_np)) ? TW'(1) : TW'(0);
                    end
                    r_turn        <= '0;
                    r_guess_ready <= 1'b1;
                    r_state       <= WAIT;
                end
                WAIT: begin
                    if (bus.guess_valid && r_guess_ready) begin
                        r_guess       <= bus.guess_img;
                        r_off         <= NPW'(1);
                        r_guess_ready <= 1'b0;
                        r_state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_occupied)
                        r_off <= r_off + NPW'(1);
                    else
                        r_state <= RESOLVE;
                end
                RESOLVE: begin
                    r_result_valid <= 1'b1;
                    r_result_match <= w_match;
                    r_result_steal <= w_match && (w_steal_sum != '0);
                    if (w_match) begin
                        for (int j = 0; j < MAX_PLAYERS; j++) begin
                            if (w_steal_mask[j])
                                r_tails[j] <= '0;
                        end
                        r_pos[r_turn]   <= w_target;
                        r_tails[r_turn] <= w_new_tails;
                        if (w_win) begin
                            r_winner_valid <= 1'b1;
                            r_winner       <= r_turn;
                            r_state        <= WIN;
                        end else begin
                            r_guess_ready <= 1'b1;
                            r_state       <= WAIT;
                        end
                    end else begin
                        r_turn        <= w_next;
                        r_guess_ready <= 1'b1;
                        r_state       <= WAIT;
                    end
                end
                WIN: begin
                    if (start) begin
                        r_np           <= w_np_clamped;
                        r_winner_valid <= 1'b0;
                        r_state        <= SETUP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dbg_pos   = '0;
        dbg_tails = '0;
        if (int'(dbg_sel) < MAX_PLAYERS) begin
            dbg_pos   = r_pos[dbg_sel];
            dbg_tails = r_tails[dbg_sel];
        end
    end

    assign bus.guess_ready  = r_guess_ready;
    assign bus.result_valid = r_result_valid;
    assign bus.result_match = r_result_match;
    assign bus.result_steal = r_result_steal;
    assign turn             = r_turn;
    assign winner_valid     = r_winner_valid;
    assign winner           = r_winner;

endmodule

// File: tb/tb_chicken_game_core.sv
// Directed bench for chicken_game_core (MAX_PLAYERS=4, TRACK_LEN=16, tile[i]=i);
// expected guess outcomes are queued at drive time and checked on result_valid.
module tb_chicken_game_core;

    localparam int MP = 4;
    localparam int TL = 16;
    localparam int IW = 4;
    localparam int PW = 2;
    localparam int AW = 4;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW:0]   num_players;
    logic          tile_wr_en;
    logic [AW-1:0] tile_wr_addr;
    logic [IW-1:0] tile_wr_img;
    logic [PW-1:0] turn;
    logic          winner_valid;
    logic [PW-1:0] winner;
    logic [PW-1:0] dbg_sel;
    logic [AW-1:0] dbg_pos;
    logic [TW-1:0] dbg_tails;

    chicken_game_core_if #(.IMG_W(IW)) bus ();

    chicken_game_core #(
        .MAX_PLAYERS (MP),
        .TRACK_LEN   (TL),
        .IMG_W       (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_players  (num_players),
        .tile_wr_en   (tile_wr_en),
        .tile_wr_addr (tile_wr_addr),
        .tile_wr_img  (tile_wr_img),
        .bus          (bus),
        .turn         (turn),
        .winner_valid (winner_valid),
        .winner       (winner),
        .dbg_sel      (dbg_sel),
        .dbg_pos      (dbg_pos),
        .dbg_tails    (dbg_tails)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          match;
        logic          steal;
        logic [PW-1:0] turn;
        logic          win;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_player(input int sel, input int pos, input int tails);
        dbg_sel = PW'(sel);
        #1;
        chk($sformatf("pos%0d", sel), 32'(dbg_pos), pos);
        chk($sformatf("tails%0d", sel), 32'(dbg_tails), tails);
    endtask

    task automatic start_game(input int np);
        num_players = (PW+1)'(np);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ready_after_setup", 32'(bus.guess_ready), 1);
        chk("turn_after_setup", 32'(turn), 0);
    endtask

    task automatic guess(input logic [IW-1:0] img, input logic m, input logic s,
                         input logic [PW-1:0] t, input logic w, input int lat);
        exp_t e;
        int   cyc;
        bit   seen;
        e.match = m;
        e.steal = s;
        e.turn  = t;
        e.win   = w;
        e.lat   = lat;
        sb.push_back(e);
        chk("ready_before_guess", 32'(bus.guess_ready), 1);
        bus.guess_valid = 1'b1;
        bus.guess_img   = img;
        tick();
        bus.guess_valid = 1'b0;
        bus.guess_img   = '0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (bus.result_valid)
                seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        chk("result_seen", 32'(seen), 1);
        e = sb.pop_front();
        chk("latency", cyc, e.lat);
        chk("result_match", 32'(bus.result_match), 32'(e.match));
        chk("result_steal", 32'(bus.result_steal), 32'(e.steal));
        chk("turn", 32'(turn), 32'(e.turn));
        chk("winner_valid", 32'(winner_valid), 32'(e.win));
        chk("ready_with_result", 32'(bus.guess_ready), 32'(!e.win));
        if (e.win)
            chk("winner", 32'(winner), 32'(e.turn));
        tick();
        chk("result_pulse_width", 32'(bus.result_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        num_players     = '0;
        tile_wr_en      = 1'b0;
        tile_wr_addr    = '0;
        tile_wr_img     = '0;
        dbg_sel         = '0;
        bus.guess_valid = 1'b0;
        bus.guess_img   = '0;

        // Reset held for two cycles: every output clear.
        tick();
        tick();
        chk("rst_ready", 32'(bus.guess_ready), 0);
        chk("rst_result_valid", 32'(bus.result_valid), 0);
        chk("rst_result_match", 32'(bus.result_match), 0);
        chk("rst_result_steal", 32'(bus.result_steal), 0);
        chk("rst_turn", 32'(turn), 0);
        chk("rst_winner_valid", 32'(winner_valid), 0);
        chk("rst_winner", 32'(winner), 0);
        for (int i = 0; i < MP; i++)
            chk_player(i, 0, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < TL; i++) begin
            tile_wr_en   = 1'b1;
            tile_wr_addr = AW'(i);
            tile_wr_img  = IW'(i);
            tick();
        end
        tile_wr_en = 1'b0;

        // Two players: p0 at 0, p1 at 4.
        start_game(2);
        chk_player(0, 0, 1);
        chk_player(1, 4, 1);
        chk_player(2, 8, 0);
        chk_player(3, 12, 0);
        tick();

        guess(4'd1, 1'b1, 1'b0, 2'd0, 1'b0, 3);
        chk_player(0, 1, 1);
        tick();

        guess(4'd7, 1'b0, 1'b0, 2'd1, 1'b0, 3);
        chk_player(0, 1, 1);
        chk_player(1, 4, 1);
        tick();

        guess(4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3);
        guess(4'd2, 1'b1, 1'b0, 2'd0, 1'b0, 3);
        guess(4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 3);
        chk_player(0, 3, 1);
        chk_player(1, 4, 1);
        tick();

        // p0 jumps over p1 on tile 4, lands on 5, takes its tail and wins.
        guess(4'd5, 1'b1, 1'b1, 2'd0, 1'b1, 4);
        chk_player(0, 5, 2);
        chk_player(1, 4, 0);
        tick();

        bus.guess_valid = 1'b1;
        bus.guess_img   = 4'd6;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("win_guess_ignored", 32'(bus.result_valid), 0);
        end
        bus.guess_valid = 1'b0;
        chk("win_held", 32'(winner_valid), 1);

        // Restart from WIN with an over-range player count.
        start_game(7);
        chk("winner_cleared", 32'(winner_valid), 0);
        chk_player(0, 0, 1);
        chk_player(1, 4, 1);
        chk_player(2, 8, 1);
        chk_player(3, 12, 1);
        tick();

        num_players = 3'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("start_in_wait_ready", 32'(bus.guess_ready), 1);
        chk_player(3, 12, 1);
        tick();

        tile_wr_en   = 1'b1;
        tile_wr_addr = 4'd1;
        tile_wr_img  = 4'd9;
        tick();
        tile_wr_en = 1'b0;
        guess(4'd9, 1'b0, 1'b0, 2'd1, 1'b0, 3);
        guess(4'd5, 1'b1, 1'b0, 2'd1, 1'b0, 3);
        chk_player(1, 5, 1);
        tick();

        // Reset while the guess is in SCAN.
        chk("ready_before_abort", 32'(bus.guess_ready), 1);
        bus.guess_valid = 1'b1;
        bus.guess_img   = 4'd6;
        tick();
        bus.guess_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", 32'(bus.guess_ready), 0);
        chk("abort_result_valid", 32'(bus.result_valid), 0);
        chk("abort_turn", 32'(turn), 0);
        chk_player(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_pulse", 32'(bus.result_valid), 0);
        end

        // Tiles were cleared: guess 0 matches tile 1, clamp of 0 gives 2 players.
        start_game(0);
        chk_player(0, 0, 1);
        chk_player(1, 4, 1);
        chk_player(2, 8, 0);
        tick();
        guess(4'd0, 1'b1, 1'b0, 2'd0, 1'b0, 3);
        chk_player(0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
